// File: rtl/mainmem_backdoor_port.sv
// mainmem_backdoor_port
//   Arbitrated backdoor port in front of the scratchpad memory wrapper.
//   Backdoor read/write requests are queued and interleaved with functional
//   accesses. Read data returns on a valid/ready response channel.
// Ports
//   clk, rst_n                     clock, async active-low reset
//   req_valid/ready/write/addr/wdata/mask   backdoor request channel
//   rsp_valid/ready/write/rdata             backdoor response channel
//   fn_req/write/addr/wdata/mask, fn_gnt    functional-side access
//   mem_write/addr/wdata/mask, mem_rdata    scratchpad pins (rdata 1-cycle latency)
//   bd_wr_cnt, bd_rd_cnt                    saturating completion counters
module mainmem_backdoor_port #(
  parameter  int unsigned ADDR_W       = 32,
  parameter  int unsigned DATA_W       = 64,
  parameter  int unsigned FIFO_DEPTH   = 4,
  parameter  int unsigned STARVE_LIMIT = 16,
  localparam int unsigned MASK_W       = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              fn_req,
  input  logic              fn_write,
  input  logic [ADDR_W-1:0] fn_addr,
  input  logic [DATA_W-1:0] fn_wdata,
  input  logic [MASK_W-1:0] fn_mask,
  output logic              fn_gnt,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       bd_wr_cnt,
  output logic [15:0]       bd_rd_cnt
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned WORD_W = ADDR_W - 3;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] mask;
  } bd_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RESP} state_t;

  state_t            state_q;
  bd_req_t           fifo_q [FIFO_DEPTH];
  bd_req_t           head;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q;
  logic [STV_W-1:0]  starve_q;
  logic [WORD_W-1:0] iss_word_q;
  logic              rsp_valid_q, rsp_write_q, fn_gnt_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [15:0]       wr_cnt_q, rd_cnt_q;
  logic              push, pop, empty;
  logic              unused_addr_lsb;

  // Byte offset within the 64-bit word plays no part in addressing.
  assign unused_addr_lsb = ^req_addr[2:0];

  assign head  = fifo_q[rptr_q];
  assign push  = req_valid & req_ready_q;
  assign pop   = (state_q == ISSUE);
  assign empty = (cnt_q == '0);

  // Occupancy next value; push and pop together leave it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
  end

  // Queue pointers, occupancy and registered ready (low while in reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PTR_W'(1);
      if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      cnt_q       <= cnt_d;
      req_ready_q <= (cnt_d != CNT_W'(FIFO_DEPTH));
    end
  end

  // Queue storage and issued word address; no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= '{write: req_write, word: req_addr[ADDR_W-1:3],
                                  wdata: req_wdata, mask: req_mask};
    if (pop)  iss_word_q <= head.word;
  end

  // Arbitration / response FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      fn_gnt_q    <= 1'b1;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            if (!fn_req || starve_q == STV_W'(STARVE_LIMIT)) begin
              state_q  <= ISSUE;
              starve_q <= '0;
              fn_gnt_q <= 1'b0;
            end else begin
              starve_q <= starve_q + STV_W'(1);
            end
          end
        end
        ISSUE: begin
          if (head.write) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            fn_gnt_q    <= 1'b1;
          end else begin
            state_q <= RDWAIT;
          end
        end
        RDWAIT: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= 1'b0;
          rsp_rdata_q <= mem_rdata;
          fn_gnt_q    <= 1'b1;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            if (rsp_write_q) begin
              if (wr_cnt_q != 16'hFFFF) wr_cnt_q <= wr_cnt_q + 16'd1;
            end else begin
              if (rd_cnt_q != 16'hFFFF) rd_cnt_q <= rd_cnt_q + 16'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Memory pin mux: functional passthrough except while the backdoor owns the port.
  always_comb begin
    mem_write = fn_req & fn_write;
    mem_addr  = fn_addr;
    mem_wdata = fn_wdata;
    mem_mask  = fn_mask;
    unique case (state_q)
      ISSUE: begin
        mem_write = head.write;
        mem_addr  = {head.word, 3'b000};
        mem_wdata = head.wdata;
        mem_mask  = head.write ? head.mask : '0;
      end
      RDWAIT: begin
        mem_write = 1'b0;
        mem_addr  = {iss_word_q, 3'b000};
        mem_wdata = '0;
        mem_mask  = '0;
      end
      default: ;
    endcase
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign fn_gnt    = fn_gnt_q;
  assign bd_wr_cnt = wr_cnt_q;
  assign bd_rd_cnt = rd_cnt_q;

endmodule

// File: tb/tb_mainmem_backdoor_port.sv
// Testbench for mainmem_backdoor_port: scratchpad model, in-order backdoor
// reference model with expected-response queue, directed and random traffic.
module tb_mainmem_backdoor_port;
  localparam int unsigned AW = 32, DW = 64, MW = 8, DEPTH = 4, LIMIT = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [MW-1:0] req_mask;
  logic          rsp_valid, rsp_ready, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          fn_req, fn_write, fn_gnt;
  logic [AW-1:0] fn_addr;
  logic [DW-1:0] fn_wdata;
  logic [MW-1:0] fn_mask;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [MW-1:0] mem_mask;
  logic [DW-1:0] mem_rdata = '0;
  logic [15:0]   bd_wr_cnt, bd_rd_cnt;

  mainmem_backdoor_port #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
    .fn_req(fn_req), .fn_write(fn_write), .fn_addr(fn_addr), .fn_wdata(fn_wdata),
    .fn_mask(fn_mask), .fn_gnt(fn_gnt),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_mask(mem_mask),
    .mem_rdata(mem_rdata), .bd_wr_cnt(bd_wr_cnt), .bd_rd_cnt(bd_rd_cnt)
  );

  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                        input logic [7:0] m);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Scratchpad: registered read, masked write, never reset.
  logic [63:0] spm [logic [28:0]];
  always @(posedge clk) begin
    mem_rdata <= spm.exists(mem_addr[31:3]) ? spm[mem_addr[31:3]] : 64'h0;
    if (mem_write)
      spm[mem_addr[31:3]] = merge(spm.exists(mem_addr[31:3]) ? spm[mem_addr[31:3]] : 64'h0,
                                  mem_wdata, mem_mask);
  end

  // Reference model: backdoor ops complete in acceptance order, so the
  // expected response is fixed when a request is accepted.
  logic [63:0] bdm [logic [28:0]];
  bit          exp_w_q [$];
  logic [63:0] exp_d_q [$];
  int unsigned exp_wr = 0, exp_rd = 0, n_acc = 0, n_rsp = 0;
  bit          hold_pend = 0, hold_w;
  logic [63:0] hold_d;

  initial begin : monitor
    logic [28:0] w;
    logic [63:0] cur;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_w_q.delete();
        exp_d_q.delete();
        exp_wr = 0;
        exp_rd = 0;
        hold_pend = 0;
      end else begin
        check("wr_cnt", 64'(bd_wr_cnt), 64'(exp_wr));
        check("rd_cnt", 64'(bd_rd_cnt), 64'(exp_rd));
        if (fn_gnt) begin
          check("pt_addr", 64'(mem_addr), 64'(fn_addr));
          check("pt_wr", 64'(mem_write), 64'(fn_req & fn_write));
          check("pt_wdata", mem_wdata, fn_wdata);
        end
        if (hold_pend) begin
          check("hold_v", 64'(rsp_valid), 64'(1));
          check("hold_w", 64'(rsp_write), 64'(hold_w));
          check("hold_d", rsp_rdata, hold_d);
        end
        if (rsp_valid && rsp_ready) begin
          check("rsp_queued", 64'(exp_w_q.size() != 0), 64'(1));
          if (exp_w_q.size() != 0) begin
            check("rsp_write", 64'(rsp_write), 64'(exp_w_q[0]));
            check("rsp_rdata", rsp_rdata, exp_d_q[0]);
            if (exp_w_q[0]) exp_wr++; else exp_rd++;
            void'(exp_w_q.pop_front());
            void'(exp_d_q.pop_front());
          end
          n_rsp++;
        end
        hold_pend = rsp_valid && !rsp_ready;
        hold_w    = rsp_write;
        hold_d    = rsp_rdata;
        if (req_valid && req_ready) begin
          w   = req_addr[31:3];
          cur = bdm.exists(w) ? bdm[w] : 64'h0;
          if (req_write) begin
            bdm[w] = merge(cur, req_wdata, req_mask);
            exp_w_q.push_back(1'b1);
            exp_d_q.push_back(64'h0);
          end else begin
            exp_w_q.push_back(1'b0);
            exp_d_q.push_back(cur);
          end
          n_acc++;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    int n = 0;
    req_write = w; req_addr = a; req_wdata = d; req_mask = m; req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("push_accept", 64'(req_ready), 64'(1));
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycles from accepting edge until rsp_valid is seen.
  task automatic lat(input string tag, input int exp_lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    check(tag, 64'(n - 1), 64'(exp_lat));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_w_q.size() != 0 || rsp_valid) && n < 300) begin @(negedge clk); n++; end
    check("drain", 64'(exp_w_q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic starve(input string tag, input int exp_lo);
    int hi = 0, lo = 0;
    @(negedge clk);
    while (fn_gnt && hi < 100) begin hi++; @(negedge clk); end
    while (!fn_gnt && lo < 10) begin lo++; @(negedge clk); end
    check({tag, "_hi"}, 64'(hi), 64'(LIMIT + 1));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(posedge clk); #1;
  endtask

  initial begin : main
    int unsigned a0, r0, w0;
    int sent, cyc;
    bit acc;
    rst_n = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_mask = '0;
    rsp_ready = 0; fn_req = 0; fn_write = 0; fn_addr = '0; fn_wdata = '0; fn_mask = '0;

    // Reset values
    repeat (5) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_rspv", 64'(rsp_valid), 64'(0));
    check("rst_gnt", 64'(fn_gnt), 64'(1));
    check("rst_wcnt", 64'(bd_wr_cnt), 64'(0));
    check("rst_rcnt", 64'(bd_rd_cnt), 64'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("ready_pre", 64'(req_ready), 64'(0));
    @(negedge clk);
    check("ready_post", 64'(req_ready), 64'(1));
    @(posedge clk); #1;

    // Basic write then read with latency
    rsp_ready = 1'b1;
    push(1'b1, 32'h1000, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    lat("wr_lat", 2);
    check("wr_rdata", rsp_rdata, 64'h0);
    drain();
    push(1'b0, 32'h1000, 64'h0, 8'h00);
    lat("rd_lat", 3);
    check("rd_data", rsp_rdata, 64'hDEADBEEF_CAFEF00D);
    drain();
    check("wcnt1", 64'(bd_wr_cnt), 64'(1));
    check("rcnt1", 64'(bd_rd_cnt), 64'(1));

    // Byte mask with unaligned address
    push(1'b1, 32'h1000, 64'h0, 8'hFF); drain();
    push(1'b1, 32'h1007, 64'hFFFFFFFF_FFFFFFFF, 8'h0F); drain();
    push(1'b0, 32'h1000, 64'h0, 8'h00);
    lat("mask_lat", 3);
    check("mask_rd", rsp_rdata, 64'h00000000_FFFFFFFF);
    drain();

    // Full queue under response backpressure
    rsp_ready = 1'b0;
    a0 = n_acc; r0 = n_rsp; w0 = bd_wr_cnt;
    for (int i = 0; i < 5; i++) push(1'b1, 32'h2000 + 32'(8 * i), {$urandom, $urandom}, 8'hFF);
    @(negedge clk);
    check("full_ready", 64'(req_ready), 64'(0));
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h2100;
    repeat (3) @(negedge clk);
    check("full_block", 64'(n_acc - a0), 64'(5));
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    check("full_rsp", 64'(n_rsp - r0), 64'(5));
    check("full_wcnt", 64'(bd_wr_cnt - 16'(w0)), 64'(5));

    // Starvation preemption
    fn_req = 1'b1; fn_write = 1'b0; fn_addr = 32'h8000_0040;
    push(1'b1, 32'h3000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    starve("stv_wr", 1);
    fn_req = 1'b0; drain();
    fn_req = 1'b1;
    push(1'b0, 32'h3000, 64'h0, 8'h00);
    starve("stv_rd", 2);
    fn_req = 1'b0; drain();

    // Reset while a read sits in RDWAIT
    push(1'b0, 32'h1000, 64'h0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rdwait_gnt", 64'(fn_gnt), 64'(0));
    rst_n = 1'b0; #1;
    check("mid_rst_gnt", 64'(fn_gnt), 64'(1));
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_rspv", 64'(rsp_valid), 64'(0));
      check("post_rst_gnt", 64'(fn_gnt), 64'(1));
    end
    @(posedge clk); #1;

    // Random traffic against the reference model
    sent = 0; cyc = 0;
    while ((sent < 80 || exp_w_q.size() != 0 || rsp_valid) && cyc < 4000) begin
      fn_req   = ($urandom_range(0, 1) == 1);
      fn_write = ($urandom_range(0, 1) == 1);
      fn_addr  = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 3);
      fn_wdata = {$urandom, $urandom};
      fn_mask  = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!req_valid && sent < 80 && $urandom_range(0, 1) == 1) begin
        req_write = ($urandom_range(0, 1) == 1);
        req_addr  = (32'($urandom_range(0, 31)) << 3) | 32'($urandom_range(0, 7));
        req_wdata = {$urandom, $urandom};
        req_mask  = 8'($urandom);
        req_valid = 1'b1;
      end
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk); #1;
      if (acc) begin req_valid = 1'b0; sent++; end
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'(80));
    fn_req = 1'b0; rsp_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
